// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and constants for the serial magnitude comparator
package cmp_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index counter width; a single-nibble compare still needs a 1-bit index.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/Comparator4Bit.sv
// rtl/Comparator4Bit.sv - 4-bit cascadable magnitude comparator slice
module Comparator4Bit (
  input  logic [3:0] a_ip,
  input  logic [3:0] b_ip,
  input  logic       a_ip_G,
  input  logic       b_ip_G,
  input  logic       a_ip_E_b,
  output logic       a_op_G,
  output logic       b_op_G,
  output logic       a_op_E_b
);

  logic nib_eq;

  // A local difference dominates; only an equal nibble passes the cascade through.
  assign nib_eq   = (a_ip == b_ip);
  assign a_op_G   = (a_ip > b_ip) | (nib_eq & a_ip_G);
  assign b_op_G   = (b_ip > a_ip) | (nib_eq & b_ip_G);
  assign a_op_E_b = nib_eq & a_ip_E_b;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - wide compare sequenced MSB nibble first through one shared slice
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_ip,
  input  logic             signed_ip,
  input  logic [WIDTH-1:0] a_ip,
  input  logic [WIDTH-1:0] b_ip,
  output logic             busy_op,
  output logic             done_op,
  output logic             a_op_G,
  output logic             b_op_G,
  output logic             a_op_E_b
);

  localparam int NIB = WIDTH / NIBBLE;
  localparam int IW  = idx_width(NIB);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            sgn_q;
  logic            seen_q, pa_g_q, pb_g_q;
  logic            a_g_q, b_g_q, eq_q;
  logic            busy_q, done_q;

  logic [3:0] a_nib, b_nib, a_sl, b_sl;
  logic       msn_flip;
  logic       s_ag, s_bg, s_eq;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[i*NIBBLE +: NIBBLE];
        b_nib = b_q[i*NIBBLE +: NIBBLE];
      end
    end
  end

  // Flipping both sign bits maps two's complement onto offset binary.
  assign msn_flip = sgn_q & (idx_q == IW'(NIB - 1));
  assign a_sl     = {a_nib[3] ^ msn_flip, a_nib[2:0]};
  assign b_sl     = {b_nib[3] ^ msn_flip, b_nib[2:0]};

  Comparator4Bit u_slice (
    .a_ip     (a_sl),
    .b_ip     (b_sl),
    .a_ip_G   (1'b0),
    .b_ip_G   (1'b0),
    .a_ip_E_b (1'b1),
    .a_op_G   (s_ag),
    .b_op_G   (s_bg),
    .a_op_E_b (s_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      seen_q  <= 1'b0;
      pa_g_q  <= 1'b0;
      pb_g_q  <= 1'b0;
      a_g_q   <= 1'b0;
      b_g_q   <= 1'b0;
      eq_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ip) begin
            a_q     <= a_ip;
            b_q     <= b_ip;
            sgn_q   <= signed_ip;
            idx_q   <= IW'(NIB - 1);
            seen_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (EARLY_EXIT && !s_eq) begin
            a_g_q   <= s_ag;
            b_g_q   <= s_bg;
            eq_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (idx_q == '0) begin
            // Fixed-latency walk: the first unequal nibble wins over later ones.
            if (seen_q) begin
              a_g_q <= pa_g_q;
              b_g_q <= pb_g_q;
              eq_q  <= 1'b0;
            end else begin
              a_g_q <= s_ag;
              b_g_q <= s_bg;
              eq_q  <= s_eq;
            end
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            if (!seen_q && !s_eq) begin
              seen_q <= 1'b1;
              pa_g_q <= s_ag;
              pb_g_q <= s_bg;
            end
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_op  = busy_q;
  assign done_op  = done_q;
  assign a_op_G   = a_g_q;
  assign b_op_G   = b_g_q;
  assign a_op_E_b = eq_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb/tb_serial_cmp_ctrl.sv - self-checking bench for serial_cmp_ctrl (early-exit and fixed-latency)
module tb_serial_cmp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        sgn_i;
  logic [15:0] a_i, b_i;

  logic busy1, done1, ag1, bg1, eq1;
  logic busy0, done0, ag0, bg0, eq0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_cmp_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start_ip(start_i), .signed_ip(sgn_i),
    .a_ip(a_i), .b_ip(b_i),
    .busy_op(busy1), .done_op(done1),
    .a_op_G(ag1), .b_op_G(bg1), .a_op_E_b(eq1)
  );

  serial_cmp_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut_fixed (
    .clk(clk), .rst(rst), .start_ip(start_i), .signed_ip(sgn_i),
    .a_ip(a_i), .b_ip(b_i),
    .busy_op(busy0), .done_op(done0),
    .a_op_G(ag0), .b_op_G(bg0), .a_op_E_b(eq0)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          s;
    logic [2:0]  res;   // {a>b, b>a, equal}
    int          k;     // nibbles examined with early exit
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer compare; k is found from the highest differing nibble.
  function automatic logic [2:0] model_res(input logic [15:0] a, input logic [15:0] b, input bit s);
    longint av, bv;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_k(input logic [15:0] a, input logic [15:0] b);
    for (int n = 3; n >= 0; n--)
      if (a[n*4 +: 4] != b[n*4 +: 4]) return 4 - n;
    return 4;
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input bit s);
    @(negedge clk);
    a_i = a; b_i = b; sgn_i = s; start_i = 1'b1;
  endtask

  // Called in the negedge of T0 (start already driven). Observes T1..T8.
  task automatic collect(input string tag, input logic [2:0] er, input int k1, input bit poke);
    int d1, d0, n1, n0;
    logic [2:0] r1, r0;
    d1 = -1; d0 = -1; n1 = 0; n0 = 0; r1 = '0; r0 = '0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check({tag, "_busy_t1"}, {30'b0, busy1, busy0}, 32'h3);
        if (poke) begin
          a_i = ~a_i; b_i = ~b_i; sgn_i = ~sgn_i;
        end else start_i = 1'b0;
      end
      if (cyc == 2) start_i = 1'b0;
      if (done1) begin n1++; if (d1 < 0) begin d1 = cyc; r1 = {ag1, bg1, eq1}; end end
      if (done0) begin n0++; if (d0 < 0) begin d0 = cyc; r0 = {ag0, bg0, eq0}; end end
    end
    check({tag, "_ee_ndone"}, n1, 1);
    check({tag, "_ee_donecyc"}, d1, k1 + 1);
    check({tag, "_ee_res"}, {29'b0, r1}, {29'b0, er});
    check({tag, "_fx_ndone"}, n0, 1);
    check({tag, "_fx_donecyc"}, d0, 5);
    check({tag, "_fx_res"}, {29'b0, r0}, {29'b0, er});
    check({tag, "_idle_busy"}, {30'b0, busy1, busy0}, 32'h0);
    check({tag, "_hold_ee"}, {29'b0, ag1, bg1, eq1}, {29'b0, er});
    check({tag, "_hold_fx"}, {29'b0, ag0, bg0, eq0}, {29'b0, er});
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; sgn_i = 1'b0; a_i = '0; b_i = '0;

    vecs.push_back('{16'h1234, 16'h1235, 1'b0, 3'b010, 4});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 3'b010, 1});
    vecs.push_back('{16'hABCD, 16'hABCD, 1'b0, 3'b001, 4});
    vecs.push_back('{16'hABCD, 16'hABCD, 1'b1, 3'b001, 4});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 3'b001, 4});
    vecs.push_back('{16'hF000, 16'h0FFF, 1'b0, 3'b100, 1});
    vecs.push_back('{16'h1200, 16'h1300, 1'b1, 3'b010, 2});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 3'b010, 1});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 3'b100, 1});
    vecs.push_back('{16'h7F80, 16'h7F70, 1'b1, 3'b100, 3});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ee", {27'b0, busy1, done1, ag1, bg1, eq1}, 32'h0);
    check("reset_fx", {27'b0, busy0, done0, ag0, bg0, eq0}, 32'h0);

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].s);
      collect($sformatf("vec%0d", i), vecs[i].res, vecs[i].k, 1'b0);
    end

    // Operand toggles and a second start during RUN must not disturb the compare.
    launch(16'h1234, 16'h1235, 1'b0);
    collect("poke_t1", 3'b010, 4, 1'b1);

    // start held high: one compare every k+2 = 6 cycles.
    begin
      int nd1, nd0, first1, last1, last0;
      nd1 = 0; nd0 = 0; first1 = -1; last1 = -1; last0 = -1;
      @(negedge clk);
      a_i = 16'h1234; b_i = 16'h1235; sgn_i = 1'b0; start_i = 1'b1;
      for (int cyc = 1; cyc <= 18; cyc++) begin
        @(negedge clk);
        if (done1) begin nd1++; if (first1 < 0) first1 = cyc; last1 = cyc; end
        if (done0) begin nd0++; last0 = cyc; end
      end
      start_i = 1'b0;
      check("held_ee_count", nd1, 3);
      check("held_ee_first", first1, 5);
      check("held_ee_last", last1, 17);
      check("held_fx_count", nd0, 3);
      check("held_fx_last", last0, 17);
      repeat (8) @(negedge clk);
    end

    // Reset in T2 of a 4-nibble compare, then restart in T3.
    begin
      int stray;
      stray = 0;
      launch(16'hABCD, 16'hABCD, 1'b0);
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      if (done1 || done0) stray++;
      check("rst_ee_zero", {27'b0, busy1, done1, ag1, bg1, eq1}, 32'h0);
      check("rst_fx_zero", {27'b0, busy0, done0, ag0, bg0, eq0}, 32'h0);
      rst = 1'b0;
      a_i = 16'h8000; b_i = 16'h7FFF; sgn_i = 1'b0; start_i = 1'b1;
      collect("rst_restart", 3'b100, 1, 1'b0);
      check("rst_no_done", stray, 0);
    end

    // Randomized operands against the integer reference model.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] ra, rb;
      bit rs;
      int mode;
      ra = 16'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) rb = 16'($urandom);
      else if (mode == 1) rb = ra;
      else rb = ra ^ (16'h1 << $urandom_range(0, 15));
      rs = 1'($urandom);
      launch(ra, rb, rs);
      collect($sformatf("rnd%0d", it), model_res(ra, rb, rs), model_k(ra, rb), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
